// File: rtl/ov2640_sccb_sender.sv
// SCCB 3-phase write engine that walks an external OV2640 register table.
// It frames each {DEV_ID, reg, value} write with START/STOP and holds the bus idle after a sensor soft reset.
module ov2640_sccb_sender #(
    parameter int unsigned CLK_DIV   = 250,
    parameter logic [7:0]  DEV_ID    = 8'h60,
    parameter logic [23:0] RST_DELAY = 24'd1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] command,
    input  logic        finished,
    output logic        resend,
    output logic        advance,
    output logic        sioc,
    output logic        siod_o,
    output logic        siod_oe,
    output logic        busy,
    output logic        done,
    output logic [2:0]  dbg_state_o
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GAP   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_BITS  = 3'd4,
        ST_STOP  = 3'd5,
        ST_DELAY = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    localparam logic [15:0] DIV_LAST       = 16'(CLK_DIV - 1);
    localparam logic [4:0]  BIT_LAST       = 5'd26;
    localparam logic [23:0] DLY_LAST       = RST_DELAY - 24'd1;
    localparam logic [15:0] SOFT_RESET_CMD = 16'h1280;

    state_t      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [4:0]  bit_q, bit_d;
    logic [23:0] dly_q, dly_d;
    logic [26:0] shift_q, shift_d;
    logic        soft_rst_q, soft_rst_d;
    logic        resend_q, resend_d;
    logic        advance_q, advance_d;
    logic        sioc_q, siod_q, oe_q;
    logic [2:0]  bus_d;
    logic        q_end;
    logic        last_qtr;

    // Bus levels {sioc, siod_o, siod_oe} for a given position in the frame.
    // Released positions drive siod_o high so the pad value matches the pull-up.
    function automatic logic [2:0] bus_levels(input state_t st, input logic [1:0] qtr,
                                              input logic [4:0] bit_idx, input logic bit_val);
        logic       dont_care;
        logic [2:0] lv;
        dont_care = (bit_idx == 5'd8) || (bit_idx == 5'd17) || (bit_idx == 5'd26);
        lv        = 3'b110;
        case (st)
            ST_START: begin
                case (qtr)
                    2'd0:    lv = 3'b111;
                    2'd1:    lv = 3'b101;
                    2'd2:    lv = 3'b101;
                    default: lv = 3'b001;
                endcase
            end
            ST_BITS:  lv = {qtr[1], bit_val | dont_care, ~dont_care};
            ST_STOP: begin
                case (qtr)
                    2'd0:    lv = 3'b001;
                    2'd1:    lv = 3'b101;
                    default: lv = 3'b110;
                endcase
            end
            default:  lv = 3'b110;
        endcase
        return lv;
    endfunction

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        qtr_d      = qtr_q;
        bit_d      = bit_q;
        dly_d      = dly_q;
        shift_d    = shift_q;
        soft_rst_d = soft_rst_q;
        resend_d   = 1'b0;
        advance_d  = 1'b0;
        q_end      = (div_q == DIV_LAST);
        last_qtr   = q_end && (qtr_q == 2'd3);

        if (state_q inside {ST_GAP, ST_START, ST_BITS, ST_STOP}) begin
            if (q_end) begin
                div_d = '0;
                qtr_d = qtr_q + 2'd1;
            end else begin
                div_d = div_q + 16'd1;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_GAP;
                    resend_d = 1'b1;
                    div_d    = '0;
                    qtr_d    = '0;
                end
            end
            ST_GAP: begin
                if (last_qtr) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                div_d = '0;
                qtr_d = '0;
                if (finished) begin
                    state_d = ST_DONE;
                end else begin
                    // Don't-care slots are latched as 1 so siod_o mirrors the released line.
                    shift_d    = {DEV_ID, 1'b1, command[15:8], 1'b1, command[7:0], 1'b1};
                    soft_rst_d = (command == SOFT_RESET_CMD);
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (last_qtr) begin
                    state_d = ST_BITS;
                    bit_d   = '0;
                end
            end
            ST_BITS: begin
                if (last_qtr) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d   = bit_q + 5'd1;
                        shift_d = {shift_q[25:0], 1'b0};
                    end
                end
            end
            ST_STOP: begin
                if (last_qtr) begin
                    state_d = ST_DELAY;
                    dly_d   = '0;
                end
            end
            ST_DELAY: begin
                // Ordinary writes spend a single idle clk here, which sets the write-to-write spacing.
                if (dly_q == (soft_rst_q ? DLY_LAST : 24'd0)) begin
                    state_d   = ST_GAP;
                    advance_d = 1'b1;
                    div_d     = '0;
                    qtr_d     = '0;
                end else begin
                    dly_d = dly_q + 24'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        bus_d = bus_levels(state_d, qtr_d, bit_d, shift_d[26]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            qtr_q      <= '0;
            bit_q      <= '0;
            dly_q      <= '0;
            shift_q    <= '0;
            soft_rst_q <= 1'b0;
            resend_q   <= 1'b0;
            advance_q  <= 1'b0;
            sioc_q     <= 1'b1;
            siod_q     <= 1'b1;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            qtr_q      <= qtr_d;
            bit_q      <= bit_d;
            dly_q      <= dly_d;
            shift_q    <= shift_d;
            soft_rst_q <= soft_rst_d;
            resend_q   <= resend_d;
            advance_q  <= advance_d;
            sioc_q     <= bus_d[2];
            siod_q     <= bus_d[1];
            oe_q       <= bus_d[0];
        end
    end

    assign resend      = resend_q;
    assign advance     = advance_q;
    assign sioc        = sioc_q;
    assign siod_o      = siod_q;
    assign siod_oe     = oe_q;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done        = (state_q == ST_DONE);
    assign dbg_state_o = state_q;

endmodule
